accumulate_sequencer: RTL and testbench
=======================================

Name: accumulate_sequencer

Overview:
- Front-end controller that sits directly upstream of the accumulate block.
- Accepts a command giving a sample count, pulls that many samples from an input valid/ready stream, and pushes them through an external fixed-latency ahfp function pipeline.
- Generates accumulate's start/valid/finished controls aligned to the pipeline output, waits for accumulate's done, then captures and holds the final sum.
- Blocks new commands while accumulate drains, because accumulate cannot accept data during its finish sequence.

Parameters:
- DATA_W, 32, sample / result width (IEEE-754 single).
- LAT, 7, fixed latency in cycles of the external function pipeline (fn_data in to fn_res out); legal range 1..15.
- LEN_W, 16, width of the command sample count.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_start  in  1  command strobe; accepted when cmd_ready=1.
- cmd_len  in  LEN_W  number of samples in the command; sampled with cmd_start.
- cmd_ready  out  1  high only in IDLE.
- in_data  in  DATA_W  input sample.
- in_valid  in  1  sample present.
- in_ready  out  1  sample accepted when in_valid and in_ready are both high.
- fn_data  out  DATA_W  to the function pipeline: in_data on an accepted cycle, else 0 (combinational).
- fn_res  in  DATA_W  function pipeline output, LAT cycles after fn_data.
- acc_data  out  DATA_W  to accumulate data: fn_res when acc_valid=1, else 0 (combinational).
- acc_valid  out  1  to accumulate valid.
- acc_start  out  1  to accumulate start; one-cycle pulse.
- acc_finished  out  1  to accumulate finished; one-cycle pulse.
- acc_done  in  1  from accumulate done.
- acc_result  in  DATA_W  from accumulate result.
- result  out  DATA_W  captured sum.
- result_valid  out  1  high from capture until the next accepted command.

Behaviour:
- Reset (async) values:
  - state=IDLE; valid pipe = 0; remaining = 0.
  - result=0, result_valid=0.
  - acc_start, acc_finished, acc_valid = 0; in_ready=0; cmd_ready=1 after reset release.
- Registered state machine; acc_start and acc_finished are registered (decoded from state).
- State IDLE:
  - cmd_start=1 and cmd_len!=0: latch remaining=cmd_len, clear result_valid, go to START.
  - cmd_start=1 and cmd_len==0: result=0, result_valid=1 next cycle, no acc_* activity, stay IDLE.
  - cmd_start while not IDLE is ignored (cmd_ready=0).
- State START: acc_start=1 for exactly one cycle; go to RUN.
- State RUN:
  - in_ready = (remaining!=0).
  - Each accepted sample decrements remaining and shifts a 1 into a LAT-deep valid pipe; non-accepted cycles shift in 0.
  - in_valid gaps are allowed; a sample accepted in cycle t appears as acc_valid=1 with acc_data=fn_res in cycle t+LAT.
  - When the last sample is accepted (remaining 1->0), go to FLUSH.
- State FLUSH: in_ready=0; keep shifting; when the valid pipe is all zero (last acc_valid has been driven), go to FINISH.
- State FINISH: acc_finished=1 for one cycle; go to WAIT_DONE.
- State WAIT_DONE:
  - When acc_done=1: result<=acc_result, result_valid<=1, go to IDLE.
  - acc_valid is guaranteed 0 and no input is accepted while waiting.
- Ordering guarantees:
  - acc_start, acc_valid and acc_finished are never high in the same cycle.
  - At least one cycle separates acc_start from the first acc_valid.
  - acc_finished occurs only after the last acc_valid.
- Count width: remaining is LEN_W bits; the maximum command is 2^LEN_W-1 samples; no wrap.
- Reset mid-operation:
  - All state clears immediately; acc_* outputs drop to 0; in-flight function results are discarded.
  - The downstream accumulator (which has no reset) is cleared by the next command's acc_start.

Test Plan:
- Reset, then cmd_len=4 with back-to-back inputs 1.0, 2.0, 3.0, 4.0 (identity function, LAT=7) -> acc_start one cycle, acc_valid high exactly 4 cycles at t_accept+7, acc_finished once after them; model acc_done with result 10.0 (0x41200000) -> result=0x41200000, result_valid=1.
- cmd_len=3 with in_valid toggling 1,0,1,0,1 -> acc_valid pattern reproduces the gaps shifted by 7 cycles; exactly 3 valids; acc_finished only after the third.
- cmd_len=0 -> result=0, result_valid=1 one cycle later, no acc_start/acc_valid/acc_finished.
- cmd_start pulsed during RUN and WAIT_DONE -> ignored, cmd_ready=0, count unchanged; acc_done withheld 50 cycles -> in_ready stays 0 throughout.
- Assert rst during RUN after 2 of 5 samples -> same-cycle return of all acc_* to 0, cmd_ready=1 after release, result_valid=0; a new cmd_len=1 then completes normally.
- Second command after completion -> result_valid drops on acceptance, and the new result replaces the old one on acc_done.

Source files
------------

// File: rtl/accumulate_sequencer.sv
// Front-end sequencer for the accumulate block: pulls a counted burst of samples
// through an external fixed-latency function pipeline and frames it with start/finished.
module accumulate_sequencer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LAT    = 7,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_start,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] fn_data,
  input  logic [DATA_W-1:0] fn_res,
  output logic [DATA_W-1:0] acc_data,
  output logic              acc_valid,
  output logic              acc_start,
  output logic              acc_finished,
  input  logic              acc_done,
  input  logic [DATA_W-1:0] acc_result,
  output logic [DATA_W-1:0] result,
  output logic              result_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_FLUSH,
    S_FINISH,
    S_WAIT_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [LAT-1:0]    vpipe_q, vpipe_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              result_valid_q, result_valid_d;
  logic              cmd_ready_q;
  logic              in_ready_q;
  logic              acc_start_q;
  logic              acc_finished_q;
  logic              accept;

  assign accept = in_valid & in_ready_q;

  // Next-state and datapath decode.
  always_comb begin
    state_d        = state_q;
    remaining_d    = remaining_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    // The valid pipe mirrors the external function pipeline, one bit per stage.
    vpipe_d        = LAT'({vpipe_q, accept});

    case (state_q)
      S_IDLE: begin
        if (cmd_start) begin
          if (cmd_len != '0) begin
            remaining_d    = cmd_len;
            result_valid_d = 1'b0;
            state_d        = S_START;
          end else begin
            result_d       = '0;
            result_valid_d = 1'b1;
          end
        end
      end
      S_START: state_d = S_RUN;
      S_RUN: begin
        if (accept) begin
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (vpipe_q == '0) begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (acc_done) begin
          result_d       = acc_result;
          result_valid_d = 1'b1;
          state_d        = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // All state and control outputs; controls are decoded from the next state so they align with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      remaining_q    <= '0;
      vpipe_q        <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      cmd_ready_q    <= 1'b1;
      in_ready_q     <= 1'b0;
      acc_start_q    <= 1'b0;
      acc_finished_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      remaining_q    <= remaining_d;
      vpipe_q        <= vpipe_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      cmd_ready_q    <= (state_d == S_IDLE);
      in_ready_q     <= (state_d == S_RUN) && (remaining_d != '0);
      acc_start_q    <= (state_d == S_START);
      acc_finished_q <= (state_d == S_FINISH);
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign in_ready     = in_ready_q;
  assign acc_start    = acc_start_q;
  assign acc_finished = acc_finished_q;
  assign acc_valid    = vpipe_q[LAT-1];
  assign result       = result_q;
  assign result_valid = result_valid_q;

  // Zero the data buses outside their valid cycles so downstream never sees stale values.
  assign fn_data  = accept    ? in_data : '0;
  assign acc_data = acc_valid ? fn_res  : '0;

endmodule

// File: tb/tb_accumulate_sequencer.sv
// Self-checking bench: identity function pipeline, behavioural accumulator and
// an event-log reference comparing accepted samples against accumulate traffic.
module tb_accumulate_sequencer;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LAT    = 7;
  localparam int unsigned LEN_W  = 16;

  logic              clk;
  logic              rst;
  logic              cmd_start;
  logic [LEN_W-1:0]  cmd_len;
  logic              cmd_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] fn_data;
  logic [DATA_W-1:0] fn_res;
  logic [DATA_W-1:0] acc_data;
  logic              acc_valid;
  logic              acc_start;
  logic              acc_finished;
  logic              acc_done;
  logic [DATA_W-1:0] acc_result;
  logic [DATA_W-1:0] result;
  logic              result_valid;

  accumulate_sequencer #(.DATA_W(DATA_W), .LAT(LAT), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_start(cmd_start), .cmd_len(cmd_len), .cmd_ready(cmd_ready),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .fn_data(fn_data), .fn_res(fn_res),
    .acc_data(acc_data), .acc_valid(acc_valid), .acc_start(acc_start),
    .acc_finished(acc_finished), .acc_done(acc_done), .acc_result(acc_result),
    .result(result), .result_valid(result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Identity function with a fixed LAT-cycle delay.
  logic [DATA_W-1:0] fnpipe [LAT];
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) fnpipe[i] <= fnpipe[i-1];
    fnpipe[0] <= fn_data;
  end
  assign fn_res = fnpipe[LAT-1];

  int n_cmp = 0;
  int n_bad = 0;

  // Event logs gathered by the monitor.
  int          start_q[$];
  int          fin_q[$];
  int          vcyc_q[$];
  logic [31:0] vdat_q[$];
  int          overlap_cnt;
  int          data_bad;
  int          rdy_bad;
  bit          watch_ready;
  int unsigned acc_sum;

  // Expectations built by the driver.
  int unsigned samp[$];
  int          acc_exp[$];

  function automatic logic [31:0] int_to_f32(input int unsigned v);
    int e;
    if (v == 0) return 32'h0;
    e = 0;
    for (int i = 0; i < 24; i++) if (v[i]) e = i;
    return {1'b0, 8'(127 + e), 23'(v << (23 - e))};
  endfunction

  function automatic int unsigned f32_to_int(input logic [31:0] b);
    int          e;
    int unsigned m;
    if (b == 32'h0) return 0;
    e = int'(b[30:23]) - 127;
    m = {9'b0, 1'b1, b[22:0]};
    return m >> (23 - e);
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (acc_start) begin
        start_q.push_back(cyc);
        acc_sum = 0;
      end
      if (acc_valid) begin
        vcyc_q.push_back(cyc);
        vdat_q.push_back(acc_data);
        acc_sum = acc_sum + f32_to_int(acc_data);
      end
      if (acc_finished) fin_q.push_back(cyc);
      if (int'(acc_start) + int'(acc_valid) + int'(acc_finished) > 1) overlap_cnt++;
      if (!acc_valid && acc_data != '0) data_bad++;
      if (!(in_valid && in_ready) && fn_data != '0) data_bad++;
      if (watch_ready && in_ready) rdy_bad++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    start_q.delete();
    fin_q.delete();
    vcyc_q.delete();
    vdat_q.delete();
    acc_exp.delete();
    overlap_cnt = 0;
    data_bad    = 0;
    rdy_bad     = 0;
  endtask

  // Push n samples from samp[]; mode 0 back-to-back, 1 alternating, 2 random gaps.
  task automatic feed(input int n, input int mode);
    int idx = 0;
    int k = 0;
    int guard = 0;
    bit v;
    while (!in_ready && guard < 10) begin
      step();
      guard++;
    end
    guard = 0;
    while (idx < n && guard < n * 20 + 50) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 2 == 0) : 1'($urandom_range(0, 1));
      in_valid = v;
      in_data  = v ? int_to_f32(samp[idx]) : $urandom;
      if (v && in_ready) begin
        acc_exp.push_back(cyc);
        idx++;
      end
      step();
      k++;
      guard++;
    end
    in_valid = 1'b0;
    in_data  = $urandom;
    check("feed_count", idx, n);
  endtask

  task automatic run_full(input int len, input int mode, input int done_dly, input bit pulse_ign);
    int          c0;
    int          k;
    int          nv;
    int unsigned sum;
    clear_logs();
    samp.delete();
    sum = 0;
    for (int i = 0; i < len; i++) begin
      samp.push_back((mode == 0) ? i + 1 : $urandom_range(1, 100));
      sum += samp[i];
    end
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_start = 1'b1;
    cmd_len   = LEN_W'(len);
    c0        = cyc;
    step();
    cmd_start = 1'b0;
    check("rv_clear_on_accept", result_valid, 0);
    check("cmd_ready_busy", cmd_ready, 0);
    if (pulse_ign) begin
      step();
      cmd_start = 1'b1;
      cmd_len   = LEN_W'(99);
      check("cmd_ready_run", cmd_ready, 0);
      step();
      cmd_start = 1'b0;
    end
    feed(len, mode);
    k = 0;
    while (fin_q.size() == 0 && k < 300) begin
      step();
      k++;
    end
    check("finish_seen", 32'(fin_q.size() != 0), 1);
    if (pulse_ign) begin
      cmd_start   = 1'b1;
      cmd_len     = LEN_W'(77);
      step();
      cmd_start   = 1'b0;
      watch_ready = 1'b1;
      in_valid    = 1'b1;
      in_data     = int_to_f32(5);
      repeat (50) step();
      in_valid    = 1'b0;
      watch_ready = 1'b0;
      check("in_ready_wait", rdy_bad, 0);
      check("cmd_ready_wait", cmd_ready, 0);
      check("rv_wait", result_valid, 0);
    end else begin
      repeat (done_dly) step();
    end
    acc_result = int_to_f32(acc_sum);
    acc_done   = 1'b1;
    step();
    acc_done   = 1'b0;
    acc_result = $urandom;
    check("result", result, int_to_f32(sum));
    check("result_valid", result_valid, 1);
    check("cmd_ready_after", cmd_ready, 1);
    check("start_count", start_q.size(), 1);
    if (start_q.size() > 0) check("start_cycle", start_q[0], c0 + 1);
    check("valid_count", vcyc_q.size(), len);
    nv = (vcyc_q.size() < acc_exp.size()) ? vcyc_q.size() : acc_exp.size();
    for (int i = 0; i < nv; i++) begin
      check("valid_cycle", vcyc_q[i], acc_exp[i] + LAT);
      check("valid_data", vdat_q[i], int_to_f32(samp[i]));
    end
    if (start_q.size() > 0 && vcyc_q.size() > 0)
      check("start_gap", 32'(vcyc_q[0] - start_q[0] >= 2), 1);
    check("finish_count", fin_q.size(), 1);
    if (fin_q.size() > 0 && vcyc_q.size() > 0)
      check("finish_after_last",
            32'(fin_q[0] > vcyc_q[vcyc_q.size()-1] && fin_q[0] <= vcyc_q[vcyc_q.size()-1] + 2), 1);
    check("overlap", overlap_cnt, 0);
    check("bus_zero", data_bad, 0);
  endtask

  initial begin
    int k;
    rst         = 1'b1;
    cmd_start   = 1'b0;
    cmd_len     = '0;
    in_data     = '0;
    in_valid    = 1'b0;
    acc_done    = 1'b0;
    acc_result  = '0;
    watch_ready = 1'b0;
    acc_sum     = 0;
    clear_logs();
    repeat (3) step();
    rst = 1'b0;
    step();

    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_in_ready", in_ready, 0);
    check("rst_result", result, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_acc_ctl", {acc_start, acc_valid, acc_finished}, 0);

    // Four back-to-back samples 1..4 -> 10.0.
    run_full(4, 0, 3, 1'b0);
    check("t1_result_10", result, 32'h41200000);

    // Alternating valid gaps.
    run_full(3, 1, 2, 1'b0);

    // Zero-length command completes immediately with no accumulate traffic.
    clear_logs();
    cmd_start = 1'b1;
    cmd_len   = '0;
    step();
    cmd_start = 1'b0;
    check("len0_result", result, 0);
    check("len0_valid", result_valid, 1);
    check("len0_cmd_ready", cmd_ready, 1);
    repeat (5) step();
    check("len0_no_acc", start_q.size() + vcyc_q.size() + fin_q.size(), 0);

    // Commands ignored while busy; acc_done withheld 50 cycles.
    run_full(4, 2, 0, 1'b1);

    // Reset in RUN after 2 of 5 samples, while a result is in flight.
    clear_logs();
    samp.delete();
    for (int i = 0; i < 5; i++) samp.push_back(i + 7);
    cmd_start = 1'b1;
    cmd_len   = LEN_W'(5);
    step();
    cmd_start = 1'b0;
    feed(2, 0);
    k = 0;
    while (!acc_valid && k < 12) begin
      step();
      k++;
    end
    check("pre_rst_valid", acc_valid, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_acc_ctl", {acc_start, acc_valid, acc_finished}, 0);
    check("mid_rst_acc_data", acc_data, 0);
    check("mid_rst_in_ready", in_ready, 0);
    step();
    rst = 1'b0;
    step();
    check("post_rst_cmd_ready", cmd_ready, 1);
    check("post_rst_rv", result_valid, 0);
    check("post_rst_result", result, 0);
    clear_logs();
    repeat (10) step();
    check("post_rst_no_valid", vcyc_q.size(), 0);
    run_full(1, 2, 3, 1'b0);

    // Random commands back to back; each replaces the previous result.
    for (int t = 0; t < 4; t++) begin
      run_full($urandom_range(1, 12), 2, $urandom_range(0, 5), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
